// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared types and default widths for the APB master slice.
//   apb_state_e : transfer FSM states
//   sel_width() : slave-index width, never less than one bit
// ---------------------------------------------------------------------------
package apb_pkg;

   localparam int unsigned APB_ADDR_W     = 32;
   localparam int unsigned APB_DATA_W     = 32;
   localparam int unsigned APB_NUM_SLAVES = 4;
   localparam int unsigned APB_SLOT_BITS  = 12;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      DECERR = 2'd3
   } apb_state_e;

   // Index width for n slaves; a single slave still gets a 1-bit index.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// ---------------------------------------------------------------------------
// apb_addr_decoder
// Combinational window decoder: maps an address inside the slave window to
// a one-hot select and a slave index.
//   addr  in  ADDR_W      address to decode
//   en    in  1           decode enable; outputs are inactive when low
//   psel  out NUM_SLAVES  one-hot select (zero when not valid)
//   idx   out SEL_W       slave index field of addr
//   valid out 1           address hits the window and names an existing slave
// ---------------------------------------------------------------------------
module apb_addr_decoder
   import apb_pkg::*;
#(
   parameter int unsigned        NUM_SLAVES = APB_NUM_SLAVES,
   parameter int unsigned        ADDR_W     = APB_ADDR_W,
   parameter logic [ADDR_W-1:0]  BASE_ADDR  = ADDR_W'(32'h1000_0000),
   parameter int unsigned        SLOT_BITS  = APB_SLOT_BITS,
   localparam int unsigned       SEL_W      = sel_width(NUM_SLAVES)
) (
   input  logic [ADDR_W-1:0]     addr,
   input  logic                  en,
   output logic [NUM_SLAVES-1:0] psel,
   output logic [SEL_W-1:0]      idx,
   output logic                  valid
);

   localparam int unsigned HI_LSB = SLOT_BITS + SEL_W;

   logic hit;
   logic unused_lo;

   // Byte offset inside a slot does not take part in the decode.
   assign unused_lo = ^addr[SLOT_BITS-1:0];

   always_comb begin
      hit   = (addr[ADDR_W-1:HI_LSB] == BASE_ADDR[ADDR_W-1:HI_LSB]);
      idx   = addr[SLOT_BITS +: SEL_W];
      // Non-power-of-two slave counts leave index codes with no slave behind them.
      valid = en && hit && ({1'b0, idx} < (SEL_W+1)'(NUM_SLAVES));
      psel  = valid ? (NUM_SLAVES'(1) << idx) : '0;
   end

endmodule

// File: rtl/apb_master_nslv.sv
// ---------------------------------------------------------------------------
// apb_master_nslv
// APB4 master bridging a core request port to NUM_SLAVES peripherals, with
// byte strobes, slave error, decode-error and timeout responses, and
// back-to-back transfers without an IDLE bubble.
//   PCLK, PRESETn          clock, async active-low reset
//   PADDR/PWDATA/PSTRB/PWRITE/PENABLE/PSEL   APB request side
//   PRDATA/PREADY/PSLVERR  per-slave responses, slave i in lane i
//   transfer/addr/wdata/strb/write           core request
//   ready/rdata/err        one-cycle completion with read data / error
//   busy                   FSM not IDLE
// ---------------------------------------------------------------------------
module apb_master_nslv
   import apb_pkg::*;
#(
   parameter int unsigned        NUM_SLAVES  = APB_NUM_SLAVES,
   parameter int unsigned        ADDR_W      = APB_ADDR_W,
   parameter int unsigned        DATA_W      = APB_DATA_W,
   parameter logic [ADDR_W-1:0]  BASE_ADDR   = ADDR_W'(32'h1000_0000),
   parameter int unsigned        SLOT_BITS   = APB_SLOT_BITS,
   parameter int unsigned        TIMEOUT_CYC = 256
) (
   input  logic                         PCLK,
   input  logic                         PRESETn,
   output logic [ADDR_W-1:0]            PADDR,
   output logic [DATA_W-1:0]            PWDATA,
   output logic [DATA_W/8-1:0]          PSTRB,
   output logic                         PWRITE,
   output logic                         PENABLE,
   output logic [NUM_SLAVES-1:0]        PSEL,
   input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]        PREADY,
   input  logic [NUM_SLAVES-1:0]        PSLVERR,
   input  logic                         transfer,
   input  logic [ADDR_W-1:0]            addr,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          strb,
   input  logic                         write,
   output logic                         ready,
   output logic [DATA_W-1:0]            rdata,
   output logic                         err,
   output logic                         busy
);

   localparam int unsigned STRB_W  = DATA_W / 8;
   localparam int unsigned SEL_W   = sel_width(NUM_SLAVES);
   localparam int unsigned CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int unsigned TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

   apb_state_e              state_q, state_d;
   logic [ADDR_W-1:0]       addr_q, addr_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [STRB_W-1:0]       strb_q, strb_d;
   logic                    write_q, write_d;
   logic [NUM_SLAVES-1:0]   psel_q, psel_d;
   logic [SEL_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic [NUM_SLAVES-1:0]   dec_psel;
   logic [SEL_W-1:0]        dec_idx;
   logic                    dec_valid;

   logic                    pready_sel;
   logic                    pslverr_sel;
   logic [DATA_W-1:0]       prdata_sel;
   logic                    timeout_c;
   logic                    complete_c;
   logic                    start_c;

   // Capture-time decode of the incoming core request.
   apb_addr_decoder #(
      .NUM_SLAVES (NUM_SLAVES),
      .ADDR_W     (ADDR_W),
      .BASE_ADDR  (BASE_ADDR),
      .SLOT_BITS  (SLOT_BITS)
   ) u_dec (
      .addr  (addr),
      .en    (transfer),
      .psel  (dec_psel),
      .idx   (dec_idx),
      .valid (dec_valid)
   );

   // Response mux for the slave selected by the captured request.
   always_comb begin
      pready_sel  = |(PREADY & psel_q);
      pslverr_sel = |(PSLVERR & psel_q);
      prdata_sel  = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (idx_q == SEL_W'(i)) prdata_sel = PRDATA[i*DATA_W +: DATA_W];
      end
   end

   // Completion qualifiers; a new request is accepted in IDLE or in the completion cycle.
   always_comb begin
      timeout_c  = (TIMEOUT_CYC != 0) && (state_q == ACCESS) && !pready_sel &&
                   (cnt_q == CNT_W'(TO_LAST));
      complete_c = ((state_q == ACCESS) && (pready_sel || timeout_c)) || (state_q == DECERR);
      start_c    = transfer && ((state_q == IDLE) || complete_c);
   end

   // FSM state register.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:   if (transfer) state_d = dec_valid ? SETUP : DECERR;
         SETUP:  state_d = ACCESS;
         ACCESS: if (complete_c) begin
                    if (transfer) state_d = dec_valid ? SETUP : DECERR;
                    else          state_d = IDLE;
                 end
         DECERR: begin
                    if (transfer) state_d = dec_valid ? SETUP : DECERR;
                    else          state_d = IDLE;
                 end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from state and selected slave.
   always_comb begin
      PSEL    = '0;
      PENABLE = 1'b0;
      ready   = 1'b0;
      err     = 1'b0;
      rdata   = '0;
      busy    = (state_q != IDLE);
      PADDR   = addr_q;
      PWDATA  = wdata_q;
      PSTRB   = strb_q;
      PWRITE  = write_q;
      case (state_q)
         SETUP:  PSEL = psel_q;
         ACCESS: begin
            PSEL    = psel_q;
            PENABLE = 1'b1;
            if (pready_sel) begin
               ready = 1'b1;
               err   = pslverr_sel;
               if (!write_q) rdata = prdata_sel;
            end else if (timeout_c) begin
               ready = 1'b1;
               err   = 1'b1;
            end
         end
         DECERR: begin
            ready = 1'b1;
            err   = 1'b1;
         end
         default: ;
      endcase
   end

   // Request capture and ACCESS-cycle counter.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      write_d = write_q;
      psel_d  = psel_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      if (start_c) begin
         addr_d  = addr;
         write_d = write;
         wdata_d = write ? wdata : '0;
         strb_d  = write ? strb  : '0;
         psel_d  = dec_psel;
         idx_d   = dec_idx;
      end
      if (state_q == SETUP) cnt_d = '0;
      else if ((state_q == ACCESS) && (TIMEOUT_CYC != 0)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         addr_q  <= '0;
         wdata_q <= '0;
         strb_q  <= '0;
         write_q <= 1'b0;
         psel_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         write_q <= write_d;
         psel_q  <= psel_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
